// File: rtl/iqueue_class_dispatch_fifo_pkg.sv
// Shared types for the in-order instruction queue: execution classes,
// queue entry layout and the per-lane dispatch view.
package iqueue_class_dispatch_fifo_pkg;

   localparam int NUM_EXEC_TYPES = 4;

   typedef enum logic [1:0] {
      EXEC_UNIT     = 2'd0,
      EXEC_UNIT_CMP = 2'd1,
      LDR_STR       = 2'd2,
      BRANCH        = 2'd3
   } enum_instr_execution_type;

   typedef struct packed {
      enum_instr_execution_type exec_type;
      logic [5:0]               op;
   } type_opcode;

   typedef struct packed {
      type_opcode  opcode;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [15:0] imm;
   } type_iqueue_entry;

   typedef struct packed {
      logic             valid;
      type_iqueue_entry instr;
   } type_iqueue_dispatch_lane;

endpackage

// File: rtl/iqueue_class_dispatch_fifo_fifo_ptr_ctrl.sv
// Read/write pointer and occupancy bookkeeping for a power-of-two circular
// buffer; flush returns everything to the empty state in one cycle.
module fifo_ptr_ctrl
   import iqueue_class_dispatch_fifo_pkg::*;
#(
   parameter int LOG2_DEPTH = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  enq,
   input  logic                  deq,
   output logic [LOG2_DEPTH-1:0] wr_ptr,
   output logic [LOG2_DEPTH-1:0] rd_ptr,
   output logic [LOG2_DEPTH:0]   count,
   output logic                  full,
   output logic                  empty
);

   localparam logic [LOG2_DEPTH:0]   DEPTH_CNT = {1'b1, {LOG2_DEPTH{1'b0}}};
   localparam logic [LOG2_DEPTH-1:0] PTR_ONE   = LOG2_DEPTH'(1);

   logic [LOG2_DEPTH-1:0] wr_ptr_reg, wr_ptr_next;
   logic [LOG2_DEPTH-1:0] rd_ptr_reg, rd_ptr_next;
   logic [LOG2_DEPTH:0]   count_reg, count_next;

   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      count_next  = count_reg;
      if (flush) begin
         wr_ptr_next = '0;
         rd_ptr_next = '0;
         count_next  = '0;
      end else begin
         // Pointers wrap naturally because DEPTH is a power of two.
         if (enq) wr_ptr_next = wr_ptr_reg + PTR_ONE;
         if (deq) rd_ptr_next = rd_ptr_reg + PTR_ONE;
         count_next = count_reg + (LOG2_DEPTH+1)'(enq) - (LOG2_DEPTH+1)'(deq);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
      end
   end

   assign wr_ptr = wr_ptr_reg;
   assign rd_ptr = rd_ptr_reg;
   assign count  = count_reg;
   assign full   = (count_reg == DEPTH_CNT);
   assign empty  = (count_reg == '0);

endmodule

// File: rtl/iqueue_class_dispatch_fifo.sv
// In-order instruction queue: buffers decoded instructions and steers the
// head entry onto exactly one of four per-class dispatch lanes.
module iqueue_class_dispatch_fifo
   import iqueue_class_dispatch_fifo_pkg::*;
#(
   parameter int LOG2_DEPTH   = 3,
   parameter int AFULL_THRESH = (2**LOG2_DEPTH) - 2,
   parameter bit ENQ_BYPASS   = 1'b0
) (
   input  logic                      i_clk,
   input  logic                      reset,
   input  logic                      i_flush,
   input  logic                      i_enq_valid,
   input  type_iqueue_entry          i_enq_instr,
   output logic                      o_enq_ready,
   output logic [NUM_EXEC_TYPES-1:0] o_deq_valid,
   output type_iqueue_entry          o_deq_instr,
   input  logic [NUM_EXEC_TYPES-1:0] i_deq_ready,
   output logic [LOG2_DEPTH:0]       o_count,
   output logic                      o_full,
   output logic                      o_empty,
   output logic                      o_afull
);

   localparam int                  DEPTH     = 2**LOG2_DEPTH;
   localparam logic [LOG2_DEPTH:0] AFULL_CNT = (LOG2_DEPTH+1)'(AFULL_THRESH);
   localparam logic [LOG2_DEPTH:0] DEPTH_CNT = (LOG2_DEPTH+1)'(DEPTH);

   logic [LOG2_DEPTH-1:0]    wr_ptr, rd_ptr;
   logic                     enq, deq, bypass_active;
   type_iqueue_entry         mem_reg [DEPTH];
   type_iqueue_dispatch_lane head_lane;

   fifo_ptr_ctrl #(.LOG2_DEPTH(LOG2_DEPTH)) u_ptr_ctrl (
      .clk    (i_clk),
      .reset  (reset),
      .flush  (i_flush),
      .enq    (enq),
      .deq    (deq),
      .wr_ptr (wr_ptr),
      .rd_ptr (rd_ptr),
      .count  (o_count),
      .full   (o_full),
      .empty  (o_empty)
   );

   // Ready depends only on state and flush, never on dequeue this cycle.
   assign o_enq_ready   = !o_full && !i_flush;
   assign enq           = i_enq_valid && o_enq_ready;
   assign o_afull       = (o_count >= AFULL_CNT);
   assign bypass_active = ENQ_BYPASS && o_empty && enq;

   always_comb begin
      head_lane.valid = !reset && !i_flush && (!o_empty || bypass_active);
      head_lane.instr = bypass_active ? i_enq_instr : mem_reg[rd_ptr];
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_EXEC_TYPES; gi++) begin : g_lane
         assign o_deq_valid[gi] = head_lane.valid &&
            (head_lane.instr.opcode.exec_type == enum_instr_execution_type'(gi));
      end
   endgenerate

   assign o_deq_instr = head_lane.instr;
   assign deq         = |(o_deq_valid & i_deq_ready);

   // A bypassed entry is also written; rd_ptr advances past it in the same cycle.
   always_ff @(posedge i_clk) begin
      if (enq) mem_reg[wr_ptr] <= i_enq_instr;
   end

   a_count_bound: assert property (@(posedge i_clk) disable iff (reset) o_count <= DEPTH_CNT);
   a_lane_onehot: assert property (@(posedge i_clk) disable iff (reset) $onehot0(o_deq_valid));

endmodule

// File: tb/tb_iqueue_class_dispatch_fifo.sv
// Randomized scoreboard bench for the class-dispatch instruction queue,
// plus directed checks of a same-cycle bypass instance.
module tb_iqueue_class_dispatch_fifo;
   import iqueue_class_dispatch_fifo_pkg::*;

   localparam int DEPTH = 8;
   localparam int AFULL = DEPTH - 2;

   logic             i_clk = 1'b0;
   logic             reset;
   logic             i_flush, i_enq_valid;
   type_iqueue_entry i_enq_instr;
   logic             o_enq_ready;
   logic [3:0]       o_deq_valid, i_deq_ready;
   type_iqueue_entry o_deq_instr;
   logic [3:0]       o_count;
   logic             o_full, o_empty, o_afull;

   logic             b_flush, b_enq_valid;
   type_iqueue_entry b_enq_instr;
   logic             b_enq_ready;
   logic [3:0]       b_deq_valid, b_deq_ready;
   type_iqueue_entry b_deq_instr;
   logic [3:0]       b_count;
   logic             b_full, b_empty, b_afull;

   int checks = 0;
   int errors = 0;
   type_iqueue_entry exp_q[$];

   always #5 i_clk = ~i_clk;

   iqueue_class_dispatch_fifo #(.LOG2_DEPTH(3), .ENQ_BYPASS(1'b0)) dut (
      .i_clk(i_clk), .reset(reset), .i_flush(i_flush), .i_enq_valid(i_enq_valid),
      .i_enq_instr(i_enq_instr), .o_enq_ready(o_enq_ready), .o_deq_valid(o_deq_valid),
      .o_deq_instr(o_deq_instr), .i_deq_ready(i_deq_ready), .o_count(o_count),
      .o_full(o_full), .o_empty(o_empty), .o_afull(o_afull));

   iqueue_class_dispatch_fifo #(.LOG2_DEPTH(3), .ENQ_BYPASS(1'b1)) dut_byp (
      .i_clk(i_clk), .reset(reset), .i_flush(b_flush), .i_enq_valid(b_enq_valid),
      .i_enq_instr(b_enq_instr), .o_enq_ready(b_enq_ready), .o_deq_valid(b_deq_valid),
      .o_deq_instr(b_deq_instr), .i_deq_ready(b_deq_ready), .o_count(b_count),
      .o_full(b_full), .o_empty(b_empty), .o_afull(b_afull));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic type_iqueue_entry mk(input enum_instr_execution_type e, input logic [5:0] op);
      type_iqueue_entry r;
      r = '0;
      r.opcode.exec_type = e;
      r.opcode.op = op;
      r.imm = 16'($urandom);
      return r;
   endfunction

   function automatic type_iqueue_entry rnd_instr();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[$bits(type_iqueue_entry)-1:0];
   endfunction

   // Monitor / scoreboard for the main instance: compare, then update the model.
   always @(negedge i_clk) begin
      int sz;
      logic [3:0] exp_lane;
      sz = exp_q.size();
      if (reset) begin
         exp_q.delete();
         check("rst_count", 64'(o_count), 64'd0);
         check("rst_empty", 64'(o_empty), 64'd1);
         check("rst_full", 64'(o_full), 64'd0);
         check("rst_afull", 64'(o_afull), 64'd0);
         check("rst_deq_valid", 64'(o_deq_valid), 64'd0);
         check("rst_enq_ready", 64'(o_enq_ready), 64'd1);
      end else begin
         check("enq_ready", 64'(o_enq_ready), 64'((sz < DEPTH) && !i_flush));
         check("count", 64'(o_count), 64'(sz));
         check("full", 64'(o_full), 64'(sz == DEPTH));
         check("empty", 64'(o_empty), 64'(sz == 0));
         check("afull", 64'(o_afull), 64'(sz >= AFULL));
         if (i_flush || sz == 0) begin
            check("deq_valid_idle", 64'(o_deq_valid), 64'd0);
         end else begin
            exp_lane = 4'b0000;
            exp_lane[int'(exp_q[0].opcode.exec_type)] = 1'b1;
            check("deq_lane", 64'(o_deq_valid), 64'(exp_lane));
            check("deq_instr", 64'(o_deq_instr), 64'(exp_q[0]));
         end
         if (i_flush) begin
            $display("flush: %0d entries discarded", sz);
            exp_q.delete();
         end else begin
            if (sz > 0 && i_deq_ready[int'(exp_q[0].opcode.exec_type)]) begin
               $display("dispatch lane=%0d instr=%h", int'(exp_q[0].opcode.exec_type), exp_q[0]);
               void'(exp_q.pop_front());
            end
            if (i_enq_valid && sz < DEPTH) exp_q.push_back(i_enq_instr);
         end
      end
   end

   task automatic drive(input logic v, input type_iqueue_entry ins, input logic [3:0] rdy, input logic fl);
      i_enq_valid = v;
      i_enq_instr = ins;
      i_deq_ready = rdy;
      i_flush     = fl;
      @(posedge i_clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      type_iqueue_entry ins, ins2;
      logic [3:0] rdy;
      reset = 1'b1;
      i_flush = 1'b0; i_enq_valid = 1'b0; i_enq_instr = '0; i_deq_ready = '0;
      b_flush = 1'b0; b_enq_valid = 1'b0; b_enq_instr = '0; b_deq_ready = '0;
      repeat (2) @(posedge i_clk);
      #1 reset = 1'b0;
      drive(1'b0, '0, 4'b0000, 1'b0);

      // Class steering: one instruction per class, all consumers ready.
      drive(1'b1, mk(EXEC_UNIT, 6'h01), 4'b1111, 1'b0);
      drive(1'b1, mk(EXEC_UNIT_CMP, 6'h02), 4'b1111, 1'b0);
      drive(1'b1, mk(LDR_STR, 6'h03), 4'b1111, 1'b0);
      drive(1'b1, mk(BRANCH, 6'h04), 4'b1111, 1'b0);
      repeat (2) drive(1'b0, '0, 4'b1111, 1'b0);

      // Head blocking: LDR at head stalls ADD behind it.
      drive(1'b1, mk(LDR_STR, 6'h05), 4'b0001, 1'b0);
      drive(1'b1, mk(EXEC_UNIT, 6'h06), 4'b0001, 1'b0);
      repeat (4) drive(1'b0, '0, 4'b0001, 1'b0);
      drive(1'b0, '0, 4'b0100, 1'b0);
      repeat (2) drive(1'b0, '0, 4'b0001, 1'b0);

      // Fill to full, try to enqueue with a dequeue, then stream at count 7.
      for (int i = 0; i < DEPTH; i++) drive(1'b1, rnd_instr(), 4'b0000, 1'b0);
      drive(1'b1, rnd_instr(), 4'b1111, 1'b0);
      for (int i = 0; i < 20; i++) drive(1'b1, rnd_instr(), 4'b1111, 1'b0);

      // Flush with concurrent enqueue and ready.
      drive(1'b1, '0, 4'b1111, 1'b1);
      for (int i = 0; i < 5; i++) drive(1'b1, rnd_instr(), 4'b0000, 1'b0);
      drive(1'b1, rnd_instr(), 4'b1111, 1'b1);
      repeat (2) drive(1'b0, '0, 4'b0000, 1'b0);

      // Randomized phases sweeping fill pressure, with sparse flushes and one reset.
      for (int c = 0; c < 1500; c++) begin
         int ph, enq_pct, rdy_pct;
         ph = (c / 150) % 3;
         enq_pct = (ph == 0) ? 85 : (ph == 1) ? 50 : 20;
         rdy_pct = (ph == 0) ? 20 : (ph == 1) ? 50 : 85;
         for (int b = 0; b < 4; b++) rdy[b] = ($urandom_range(99) < rdy_pct);
         if (c == 777) begin
            reset = 1'b1;
            drive(1'b0, '0, 4'b0000, 1'b0);
            reset = 1'b0;
         end
         drive($urandom_range(99) < enq_pct, rnd_instr(), rdy, $urandom_range(99) < 2);
      end
      repeat (12) drive(1'b0, '0, 4'b1111, 1'b0);
      drive(1'b0, '0, 4'b0000, 1'b0);

      // Bypass instance: empty queue, matching ready -> consumed same cycle.
      ins = mk(LDR_STR, 6'h2a);
      b_enq_valid = 1'b1; b_enq_instr = ins; b_deq_ready = 4'b0100;
      #1;
      check("byp_lane", 64'(b_deq_valid), 64'(4'b0100));
      check("byp_instr", 64'(b_deq_instr), 64'(ins));
      @(posedge i_clk); #1;
      b_enq_valid = 1'b0; b_deq_ready = 4'b0000;
      #1;
      check("byp_count", 64'(b_count), 64'd0);
      check("byp_empty", 64'(b_empty), 64'd1);
      check("byp_idle_valid", 64'(b_deq_valid), 64'd0);

      // Bypass instance: presented same cycle but not consumed -> stored.
      ins2 = mk(BRANCH, 6'h15);
      b_enq_valid = 1'b1; b_enq_instr = ins2; b_deq_ready = 4'b0111;
      #1;
      check("byp_stall_lane", 64'(b_deq_valid), 64'(4'b1000));
      @(posedge i_clk); #1;
      b_enq_valid = 1'b0;
      #1;
      check("byp_stall_count", 64'(b_count), 64'd1);
      check("byp_stall_instr", 64'(b_deq_instr), 64'(ins2));
      b_deq_ready = 4'b1000;
      @(posedge i_clk); #1;
      b_deq_ready = 4'b0000;
      #1;
      check("byp_drain_count", 64'(b_count), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
